ttt_referee: RTL

- Sequential game controller and referee on the move-consumer side of the tic-tac-toe AI.
- Owns the registered board: x_state (AI, X) and o_state (human, O), each 9 bits; bit k = square k; rows are [2:0], [5:3], [8:6].
- Accepts human moves over a valid/ready handshake and feeds the board to the combinational move generator.
- Commits the generator's one-hot move after a settle delay, detects wins and draws, and holds the result until a new game starts.

---
 rtl/ttt_referee.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ttt_referee.sv
// ttt_referee: tic-tac-toe game controller and referee owning the X/O boards.
// Define TTT_STATS_EN to add saturating o_wins/x_wins/draws counters.
module ttt_referee #(
  parameter int AI_DELAY     = 2,
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [3:0] move_sq,
  input  logic [8:0] ai_move,
  output logic [8:0] x_state,
  output logic [8:0] o_state,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [8:0] win_line,
  output logic       illegal,
  output logic       ai_fault
`ifdef TTT_STATS_EN
  ,
  output logic [7:0] o_wins,
  output logic [7:0] x_wins,
  output logic [7:0] draws
`endif
);
  typedef enum logic [2:0] {WAIT_O, AI_WAIT, AI_COMMIT, CHECK, DONE} state_t;
  localparam logic [3:0] DLY = 4'(AI_DELAY);
  localparam logic [8:0] LINES [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};
  state_t     r_state;
  logic [3:0] r_cnt;
  logic [8:0] r_x, r_o, r_win_line;
  logic [1:0] r_winner;
  logic       r_last, r_illegal, r_fault, r_over;
  logic [8:0] w_occ, w_empty, w_low, w_board, w_o_bit, w_lines;
  logic       w_ai_ok, w_o_ok;
  assign w_occ   = r_x | r_o;
  assign w_empty = ~w_occ;
  assign w_low   = w_empty & (~w_empty + 9'd1);
  assign w_board = r_last ? r_x : r_o;
  assign w_o_bit = 9'd1 << move_sq;
  assign w_o_ok  = (move_sq <= 4'd8) && ((w_o_bit & w_occ) == 9'd0);
  assign w_ai_ok = (ai_move != 9'd0) && ((ai_move & (ai_move - 9'd1)) == 9'd0) && ((ai_move & w_occ) == 9'd0);
  always_comb begin
    w_lines = '0;
    for (int i = 0; i < 8; i++) w_lines |= ((w_board & LINES[i]) == LINES[i]) ? LINES[i] : 9'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FIRST_PLAYER ? AI_WAIT : WAIT_O;
      r_cnt      <= DLY;
      r_x        <= '0;
      r_o        <= '0;
      r_winner   <= '0;
      r_win_line <= '0;
      r_last     <= 1'b0;
      r_illegal  <= 1'b0;
      r_fault    <= 1'b0;
      r_over     <= 1'b0;
    end else if (new_game) begin
      r_state    <= FIRST_PLAYER ? AI_WAIT : WAIT_O;
      r_cnt      <= DLY;
      r_x        <= '0;
      r_o        <= '0;
      r_winner   <= '0;
      r_win_line <= '0;
      r_illegal  <= 1'b0;
      r_fault    <= 1'b0;
      r_over     <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        WAIT_O: if (move_valid) begin
          if (w_o_ok) begin
            r_o     <= r_o | w_o_bit;
            r_last  <= 1'b0;
            r_state <= CHECK;
          end else r_illegal <= 1'b1;
        end
        CHECK: if (|w_lines) begin
          r_winner   <= r_last ? 2'b10 : 2'b01;
          r_win_line <= w_lines;
          r_over     <= 1'b1;
          r_state    <= DONE;
        end else if (&w_occ) begin
          r_winner <= 2'b00;
          r_over   <= 1'b1;
          r_state  <= DONE;
        end else if (!r_last) begin
          r_cnt   <= DLY;
          r_state <= AI_WAIT;
        end else r_state <= WAIT_O;
        AI_WAIT: if (r_cnt <= 4'd1) r_state <= AI_COMMIT; else r_cnt <= r_cnt - 4'd1;
        AI_COMMIT: begin
          // a bad AI move is replaced by the lowest empty square so play continues
          r_x     <= r_x | (w_ai_ok ? ai_move : w_low);
          r_fault <= r_fault | !w_ai_ok;
          r_last  <= 1'b1;
          r_state <= CHECK;
        end
        default: ;
      endcase
    end
  end
  assign move_ready = (r_state == WAIT_O);
  assign turn       = (r_state == AI_WAIT) || (r_state == AI_COMMIT) || ((r_state == CHECK) && !r_last);
  assign x_state    = r_x;
  assign o_state    = r_o;
  assign game_over  = r_over;
  assign winner     = r_winner;
  assign win_line   = r_win_line;
  assign illegal    = r_illegal;
  assign ai_fault   = r_fault;
`ifdef TTT_STATS_EN
  logic [7:0] r_o_wins, r_x_wins, r_draws;
  logic       w_done;
  assign w_done = (r_state == CHECK) && !new_game && ((|w_lines) || (&w_occ));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_wins <= '0;
      r_x_wins <= '0;
      r_draws  <= '0;
    end else if (w_done) begin
      if ((|w_lines) && !r_last && (r_o_wins != 8'hFF)) r_o_wins <= r_o_wins + 8'd1;
      if ((|w_lines) && r_last && (r_x_wins != 8'hFF)) r_x_wins <= r_x_wins + 8'd1;
      if (!(|w_lines) && (r_draws != 8'hFF)) r_draws <= r_draws + 8'd1;
    end
  end
  assign o_wins = r_o_wins;
  assign x_wins = r_x_wins;
  assign draws  = r_draws;
`endif
endmodule
